// File: rtl/div.sv
// rtl/div.sv - 32-bit signed/unsigned radix-2 restoring divider, result {remainder, quotient}
module div (
    input  logic        clk,
    input  logic        rst,
    input  logic        signed_div_i,
    input  logic [31:0] opdata1_i,
    input  logic [31:0] opdata2_i,
    input  logic        start_i,
    input  logic        annul_i,
    output logic [63:0] result_o,
    output logic        ready_o
);

    localparam logic [1:0] S_FREE   = 2'b00;
    localparam logic [1:0] S_BYZERO = 2'b01;
    localparam logic [1:0] S_ON     = 2'b10;
    localparam logic [1:0] S_END    = 2'b11;

    logic [1:0]  r_state;
    logic [5:0]  r_cnt;
    logic [64:0] r_dividend;
    logic [31:0] r_divisor;
    logic        r_op1_neg;
    logic        r_op2_neg;
    logic        r_sgn;

    logic        w_op1_neg;
    logic        w_op2_neg;
    logic [31:0] w_op1_abs;
    logic [31:0] w_op2_abs;
    logic [32:0] w_diff;
    logic [31:0] w_quot;
    logic [31:0] w_rem;

    assign w_op1_neg = signed_div_i & opdata1_i[31];
    assign w_op2_neg = signed_div_i & opdata2_i[31];
    assign w_op1_abs = w_op1_neg ? (~opdata1_i + 32'd1) : opdata1_i;
    assign w_op2_abs = w_op2_neg ? (~opdata2_i + 32'd1) : opdata2_i;

    // Trial subtraction of the divisor from the partial remainder; bit 32 set means it did not fit
    assign w_diff = {1'b0, r_dividend[63:32]} - {1'b0, r_divisor};

    // Quotient is negative when operand signs differ; remainder follows the dividend's sign
    assign w_quot = (r_sgn && (r_op1_neg ^ r_op2_neg)) ? (~r_dividend[31:0] + 32'd1) : r_dividend[31:0];
    assign w_rem  = (r_sgn && r_op1_neg) ? (~r_dividend[64:33] + 32'd1) : r_dividend[64:33];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= S_FREE;
            r_cnt      <= 6'd0;
            r_dividend <= 65'd0;
            r_divisor  <= 32'd0;
            r_op1_neg  <= 1'b0;
            r_op2_neg  <= 1'b0;
            r_sgn      <= 1'b0;
            result_o   <= 64'd0;
            ready_o    <= 1'b0;
        end else begin
            ready_o  <= 1'b0;
            result_o <= 64'd0;
            case (r_state)
                S_FREE: begin
                    if (start_i && !annul_i) begin
                        if (opdata2_i == 32'd0) begin
                            r_state <= S_BYZERO;
                        end else begin
                            r_dividend <= {32'd0, w_op1_abs, 1'b0};
                            r_divisor  <= w_op2_abs;
                            r_op1_neg  <= w_op1_neg;
                            r_op2_neg  <= w_op2_neg;
                            r_sgn      <= signed_div_i;
                            r_cnt      <= 6'd0;
                            r_state    <= S_ON;
                        end
                    end
                end
                S_BYZERO: begin
                    r_dividend <= 65'd0;
                    r_state    <= S_END;
                end
                S_ON: begin
                    if (annul_i) begin
                        r_cnt   <= 6'd0;
                        r_state <= S_FREE;
                    end else if (r_cnt < 6'd32) begin
                        if (w_diff[32]) begin
                            r_dividend <= {r_dividend[63:0], 1'b0};
                        end else begin
                            r_dividend <= {w_diff[31:0], r_dividend[31:0], 1'b1};
                        end
                        r_cnt <= r_cnt + 6'd1;
                    end else begin
                        r_dividend <= {w_rem, r_dividend[32], w_quot};
                        r_cnt      <= 6'd0;
                        r_state    <= S_END;
                    end
                end
                S_END: begin
                    if (start_i) begin
                        ready_o  <= 1'b1;
                        result_o <= {r_dividend[64:33], r_dividend[31:0]};
                    end else begin
                        r_state <= S_FREE;
                    end
                end
                default: r_state <= S_FREE;
            endcase
        end
    end

endmodule
